gate_controller: RTL and testbench
==================================

// Module: gate_controller
// PURPOSE
//  Upstream sequencer for the counter block: opens a counting gate on start_i, closes it on a
//  synchronised rising edge of stop_i, then captures the frozen count. Drives the counter's
//  enable, watches its finished flag, and hands {result, overflow} downstream via valid/ready.
//  Counter reset_i is tied to ~reset_n_i at the top level.
// PARAMETERS
//  MAX_COUNTER_VALUE  2000  must equal the attached counter's value; VAL_W = $clog2(MAX_COUNTER_VALUE+1)
//  SYNC_STAGES        2     flip-flop stages synchronising stop_i (legal >= 2)
// PORTS
//  clock_i             in   1      single clock, rising edge
//  reset_n_i           in   1      asynchronous, active-low reset
//  start_i             in   1      request one measurement; level sampled only in IDLE
//  stop_i              in   1      asynchronous end-of-gate signal; rising edge ends the gate
//  abort_i             in   1      cancel the measurement in progress; no result produced
//  counter_enable_o    out  1      to counter enable_i; registered
//  counter_finished_i  in   1      from counter finished_o
//  counter_val_i       in   VAL_W  from counter counter_val_o
//  result_o            out  VAL_W  captured count; stable while result_valid_o=1
//  overflow_o          out  1      count saturated at MAX_COUNTER_VALUE before the stop edge
//  result_valid_o      out  1      result available
//  result_ready_i      in   1      downstream accepts; transfer when valid && ready
//  busy_o              out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; synchroniser and edge register 0.
//  stop_i passes SYNC_STAGES flops. stop_edge = sync_out & ~sync_out_q. Edges are acted on only
//   in GATE; edges in other states are discarded.
//  FSM (all outputs registered):
//  - IDLE: enable=0, busy=0. start_i=1 -> ARM.
//  - ARM (exactly 1 cycle): enable=1. The counter detects its enable rising edge, clears value
//     and finished. counter_finished_i is ignored here because it is stale. -> GATE.
//  - GATE: enable=1. Priority: abort_i > counter_finished_i > stop_edge.
//     abort_i: enable=0 -> IDLE, no result.
//     counter_finished_i=1 (saturated): enable=0, result_o<=counter_val_i, overflow_o<=1,
//      valid=1 -> RESULT.
//     stop_edge: enable=0 -> DRAIN.
//  - DRAIN: enable=0. abort_i -> IDLE. On counter_finished_i=1 (one cycle after enable falls):
//     result_o<=counter_val_i, overflow_o<=0, valid=1 -> RESULT.
//  - RESULT: holds result_o, overflow_o and valid. abort_i is ignored.
//     valid && ready: valid=0 -> IDLE.
//  Count rule: with enable_o high for K cycles, result_o = K-1, saturating at MAX_COUNTER_VALUE.
//  start_i outside IDLE is ignored and not queued.
//  Stop latency: at most SYNC_STAGES+2 cycles from stop_i rising to enable_o low.
//  Only one result is ever pending; no new gate opens until it is accepted.
// CONFIGURATION
//  GATE_CONTROLLER_AUTO_REARM_EN
//  - Defined: a RESULT handshake moves to ARM, not IDLE, when abort_i=0. This gives continuous
//     back-to-back measurements; busy_o stays 1. abort_i in that cycle -> IDLE.
//  - Undefined: RESULT -> IDLE; every measurement needs its own start_i.
// TESTING
//  Benches use MAX_COUNTER_VALUE=15 and SYNC_STAGES=2.
//  1. Reset mid-GATE: drop reset_n_i between edges -> enable_o=0, busy_o=0, valid=0 immediately.
//  2. start_i pulse, stop_i rises so enable_o is high 10 cycles -> result_o=9, overflow_o=0.
//     valid stays high until ready.
//  3. start_i, no stop -> enable_o drops after the counter finishes, result_o=15, overflow_o=1.
//  4. abort_i in GATE and in DRAIN -> IDLE; result_valid_o never rises.
//  5. result_ready_i held low 20 cycles -> result_o/overflow_o stable; start_i and stop_i
//     ignored; transfer only on ready.
//  6. AUTO_REARM_EN defined, start once, stop toggled each 8 gate cycles, ready=1 ->
//     three consecutive results =7, ARM follows each handshake, busy_o stays 1.

Source files
------------

// File: rtl/gate_controller.sv
// gate_controller: sequencer that opens a counting gate on start_i and closes it on a
// synchronised rising edge of stop_i. It captures the frozen count and offers
// {result, overflow} downstream through a valid/ready handshake.
// Optional feature macro: GATE_CONTROLLER_AUTO_REARM_EN. When it is defined, an accepted
// result re-arms the next gate straight away, so measurements run back to back.
module gate_controller #(
    parameter int MAX_COUNTER_VALUE = 2000,
    parameter int SYNC_STAGES       = 2,
    // Derived from MAX_COUNTER_VALUE; leave at its default.
    parameter int VAL_W             = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             abort_i,
    output logic             counter_enable_o,
    input  logic             counter_finished_i,
    input  logic [VAL_W-1:0] counter_val_i,
    output logic [VAL_W-1:0] result_o,
    output logic             overflow_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t                 state_q, state_d;
    logic                   enable_q, enable_d;
    logic [VAL_W-1:0]       result_q, result_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last_q;
    logic                   sync_out;
    logic                   stop_edge;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign stop_edge = sync_out & ~sync_last_q;

    // Bring the asynchronous stop_i into the clock domain and keep the previous
    // synchronised level so that a rising edge can be detected.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q      <= '0;
            sync_last_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], stop_i};
            sync_last_q <= sync_out;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE: begin
                enable_d = 1'b0;
                valid_d  = 1'b0;
                if (start_i) begin
                    state_d  = S_ARM;
                    enable_d = 1'b1;
                end
            end

            // The counter sees enable rise at the end of this cycle. Any finished
            // flag seen here is left over from the previous run, so it is ignored.
            S_ARM: begin
                enable_d = 1'b1;
                state_d  = S_GATE;
            end

            S_GATE: begin
                if (abort_i) begin
                    enable_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (counter_finished_i) begin
                    // The counter saturated before stop arrived.
                    enable_d   = 1'b0;
                    result_d   = counter_val_i;
                    overflow_d = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = S_RESULT;
                end else if (stop_edge) begin
                    enable_d = 1'b0;
                    state_d  = S_DRAIN;
                end
            end

            // Wait for the counter to report that its value is frozen.
            S_DRAIN: begin
                enable_d = 1'b0;
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (counter_finished_i) begin
                    result_d   = counter_val_i;
                    overflow_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = S_RESULT;
                end
            end

            S_RESULT: begin
                enable_d = 1'b0;
                if (valid_q && result_ready_i) begin
                    valid_d = 1'b0;
`ifdef GATE_CONTROLLER_AUTO_REARM_EN
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_ARM;
                        enable_d = 1'b1;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end

            default: begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
                valid_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign counter_enable_o = enable_q;
    assign result_o         = result_q;
    assign overflow_o       = overflow_q;
    assign result_valid_o   = valid_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_gate_controller.sv
// Bench for gate_controller. It contains a behavioural model of the attached counter
// and derives the expected result from the number of cycles for which enable was high.
module tb_gate_controller;

    localparam int MAXV  = 15;
    localparam int SYNC  = 2;
    localparam int VW    = $clog2(MAXV + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          enable_o;
    logic          cfin;
    logic [VW-1:0] cval;
    logic [VW-1:0] result_o;
    logic          overflow_o;
    logic          valid_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;
    bit prev_en  = 1'b0;
    bit valid_seen = 1'b0;

    gate_controller #(
        .MAX_COUNTER_VALUE(MAXV),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock_i(clk),
        .reset_n_i(rst_n),
        .start_i(start_i),
        .stop_i(stop_i),
        .abort_i(abort_i),
        .counter_enable_o(enable_o),
        .counter_finished_i(cfin),
        .counter_val_i(cval),
        .result_o(result_o),
        .overflow_o(overflow_o),
        .result_valid_o(valid_o),
        .result_ready_i(ready_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Counter model: it clears on the rising edge of enable and counts while enable
    // stays high, saturating at MAXV. It raises finished on saturation or one
    // cycle after enable falls.
    logic cen_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cval  <= '0;
            cfin  <= 1'b0;
            cen_q <= 1'b0;
        end else begin
            cen_q <= enable_o;
            if (enable_o && !cen_q) begin
                cval <= '0;
                cfin <= 1'b0;
            end else if (enable_o) begin
                if (int'(cval) < MAXV) cval <= cval + 1'b1;
                if (int'(cval) >= MAXV - 1) cfin <= 1'b1;
            end else if (cen_q) begin
                cfin <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge. Also tracks how long enable
    // has been high and whether valid was ever seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (enable_o) en_cnt = prev_en ? en_cnt + 1 : 1;
        prev_en = enable_o;
        if (valid_o) valid_seen = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int b;
        b = 0;
        while (!valid_o && b < 60) begin
            tick();
            b++;
        end
        check(tag, valid_o, 1);
    endtask

    task automatic accept();
        ready_i = 1'b1;
`ifdef GATE_CONTROLLER_AUTO_REARM_EN
        abort_i = 1'b1;
`endif
        tick();
        ready_i = 1'b0;
        abort_i = 1'b0;
        check("accept_valid_low", valid_o, 0);
        check("accept_idle", busy_o, 0);
    endtask

    // Run one gate. enable stays high for wait_cycles sampled cycles, then stop rises
    // (if use_stop is set). Returns the measured number of enable-high cycles.
    task automatic run_measure(input int wait_cycles, input bit use_stop, output int k);
        int lat;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("arm_enable", enable_o, 1);
        check("arm_busy", busy_o, 1);
        repeat (wait_cycles - 1) tick();
        if (use_stop) begin
            stop_i = 1'b1;
            lat = 0;
            while (enable_o && lat < 10) begin
                tick();
                lat++;
            end
            check("stop_latency_ok", (lat <= SYNC + 2) && !enable_o, 1);
        end
        wait_valid("result_valid_timeout");
        k = en_cnt;
        stop_i = 1'b0;
    endtask

    initial begin
        int k;
        int exp;
        int w;
        logic [VW-1:0] held_r;
        logic held_o;

        // Reset state
        #12;
        check("reset_enable", enable_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_result", result_o, 0);
        check("reset_overflow", overflow_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Reset asserted between edges while the gate is open
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("pre_reset_enable", enable_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midgate_reset_enable", enable_o, 0);
        check("midgate_reset_busy", busy_o, 0);
        check("midgate_reset_valid", valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_en = 1'b0;
        repeat (3) tick();

        // Enable high for ten cycles gives a result of 9
        run_measure(8, 1'b1, k);
        check("gate10_k", k, 10);
        check("gate10_result", result_o, 9);
        check("gate10_overflow", overflow_o, 0);
        repeat (3) begin
            tick();
            check("gate10_valid_hold", valid_o, 1);
        end
        accept();
        repeat (5) tick();

        // No stop: the counter saturates
        run_measure(1, 1'b0, k);
        check("sat_result", result_o, MAXV);
        check("sat_overflow", overflow_o, 1);
        check("sat_enable_low", enable_o, 0);
        accept();
        repeat (3) tick();

        // Abort while the gate is open
        valid_seen = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_gate_enable", enable_o, 0);
        check("abort_gate_busy", busy_o, 0);
        repeat (30) tick();
        check("abort_gate_no_valid", valid_seen, 0);

        // Abort during the drain phase
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        stop_i = 1'b1;
        w = 0;
        while (enable_o && w < 10) begin
            tick();
            w++;
        end
        check("drain_reached", busy_o && !enable_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        stop_i = 1'b0;
        check("abort_drain_busy", busy_o, 0);
        repeat (10) tick();
        check("abort_drain_no_valid", valid_seen, 0);

        // Ready held low: the result stays stable, and start/stop are ignored
        run_measure(5, 1'b1, k);
        exp = (k - 1 > MAXV) ? MAXV : k - 1;
        check("hold_result", result_o, exp);
        held_r = result_o;
        held_o = overflow_o;
        for (int i = 0; i < 20; i++) begin
            start_i = 1'($urandom_range(0, 1));
            stop_i  = 1'($urandom_range(0, 1));
            tick();
            check("hold_stable_result", result_o, held_r);
            check("hold_stable_ovf", overflow_o, held_o);
            check("hold_valid", valid_o, 1);
            check("hold_no_enable", enable_o, 0);
        end
        start_i = 1'b0;
        stop_i = 1'b0;
        accept();
        repeat (6) tick();
        check("hold_no_requeue", busy_o, 0);

        // Randomised gate lengths and ready delays
        for (int n = 0; n < 8; n++) begin
            w = $urandom_range(3, 10);
            run_measure(w, 1'b1, k);
            exp = (k - 1 > MAXV) ? MAXV : k - 1;
            check("rand_result", result_o, exp);
            check("rand_overflow", overflow_o, 0);
            check("rand_k_range", (k > w) && (k <= w + SYNC + 2), 1);
            repeat ($urandom_range(0, 4)) begin
                tick();
                check("rand_valid_hold", valid_o, 1);
            end
            accept();
            repeat ($urandom_range(4, 8)) tick();
        end

`ifdef GATE_CONTROLLER_AUTO_REARM_EN
        // Back-to-back measurements: enable high for eight cycles each time
        ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            w = 0;
            while (en_cnt < 6 && w < 40) begin
                tick();
                w++;
            end
            stop_i = 1'b1;
            w = 0;
            while (enable_o && w < 10) begin
                tick();
                w++;
            end
            stop_i = 1'b0;
            wait_valid("rearm_valid_timeout");
            check("rearm_result", result_o, 7);
            check("rearm_overflow", overflow_o, 0);
            check("rearm_busy", busy_o, 1);
            if (r == 2) abort_i = 1'b1;
            tick();
            abort_i = 1'b0;
            check("rearm_valid_low", valid_o, 0);
            check("rearm_arm_enable", enable_o, (r == 2) ? 0 : 1);
            check("rearm_busy_after", busy_o, (r == 2) ? 0 : 1);
        end
        ready_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
